// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle controller and its datapath/memory.
// The controller uses the master side: it samples opcode and mem_ready and
// drives every control and status line. The datapath uses the slave side.
interface multicycle_control_if #(
    parameter int OP_SIZE     = 6,
    parameter int ALUOP_SIZE  = 4,
    parameter int COUNT_WIDTH = 32
);
    logic [OP_SIZE-1:0]     opcode;
    logic                   mem_ready;

    logic                   pcWrite;
    logic                   pcWriteCond;
    logic                   memGetData;
    logic                   memRead;
    logic                   memWrite;
    logic                   irWrite;
    logic                   regWrite;
    logic                   aluSrcA;
    logic [1:0]             regWriteDataSel;
    logic [1:0]             aluSrcB;
    logic [1:0]             pcSrc;
    logic [ALUOP_SIZE-1:0]  aluOP;

    logic [3:0]             state;
    logic                   halted;
    logic                   illegal;
    logic [COUNT_WIDTH-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output pcWrite, pcWriteCond, memGetData, memRead, memWrite, irWrite,
               regWrite, aluSrcA, regWriteDataSel, aluSrcB, pcSrc, aluOP,
               state, halted, illegal, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pcWrite, pcWriteCond, memGetData, memRead, memWrite, irWrite,
               regWrite, aluSrcA, regWriteDataSel, aluSrcB, pcSrc, aluOP,
               state, halted, illegal, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control unit for a multicycle processor datapath.
//
//  state      | meaning
//  -----------+------------------------------------------------------
//  FETCH      | read IR from mem[PC], PC <= PC+1 once memory is ready
//  DECODE     | latch opcode, precompute branch target into ALUOut
//  MEM_ADDR   | ALUOut <= regA + offset
//  MEM_READ   | read mem[ALUOut] into MDR, wait for memory
//  MEM_WB     | rd <= MDR
//  MEM_WRITE  | mem[ALUOut] <= regB, wait for memory
//  EXECUTE    | ALU on regA/regB, function from IR funct field
//  EXECUTE_I  | regA + sign-extended immediate
//  ALU_WB     | rd <= ALUOut
//  BRANCH     | compare regA/regB, PC <= ALUOut if equal
//  JUMP       | PC <= jump address
//  LOAD_IMM   | rd <= sign-extended big immediate
//  HALT       | all controls idle until reset
//
// Controls that depend only on state are registered from the next state, so
// they change cleanly at the clock edge. irWrite and pcWrite in FETCH follow
// mem_ready directly, since the IR/PC update happens in the completing cycle.
module multicycle_control #(
    parameter int OP_SIZE     = 6,
    parameter int ALUOP_SIZE  = 4,
    parameter int COUNT_WIDTH = 32,
    parameter int OP_RTYPE    = 0,
    parameter int OP_LW       = 1,
    parameter int OP_SW       = 2,
    parameter int OP_ADDI     = 3,
    parameter int OP_BEQ      = 4,
    parameter int OP_J        = 5,
    parameter int OP_LI       = 6,
    parameter int OP_HALT     = 63,
    parameter int ALU_ADD     = 0,
    parameter int ALU_SUB     = 1,
    parameter int ALU_FUNCT   = 15
) (
    input logic                 clk,
    input logic                 rst,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        EXECUTE_I = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        LOAD_IMM  = 4'd11,
        HALT      = 4'd12
    } stateT;

    typedef struct packed {
        logic                  pcWrite;
        logic                  pcWriteCond;
        logic                  memGetData;
        logic                  memRead;
        logic                  memWrite;
        logic                  regWrite;
        logic                  aluSrcA;
        logic [1:0]            regWriteDataSel;
        logic [1:0]            aluSrcB;
        logic [1:0]            pcSrc;
        logic [ALUOP_SIZE-1:0] aluOP;
    } ctrlT;

    localparam logic [OP_SIZE-1:0] OPC_RTYPE = OP_SIZE'(OP_RTYPE);
    localparam logic [OP_SIZE-1:0] OPC_LW    = OP_SIZE'(OP_LW);
    localparam logic [OP_SIZE-1:0] OPC_SW    = OP_SIZE'(OP_SW);
    localparam logic [OP_SIZE-1:0] OPC_ADDI  = OP_SIZE'(OP_ADDI);
    localparam logic [OP_SIZE-1:0] OPC_BEQ   = OP_SIZE'(OP_BEQ);
    localparam logic [OP_SIZE-1:0] OPC_J     = OP_SIZE'(OP_J);
    localparam logic [OP_SIZE-1:0] OPC_LI    = OP_SIZE'(OP_LI);
    localparam logic [OP_SIZE-1:0] OPC_HALT  = OP_SIZE'(OP_HALT);

    localparam logic [ALUOP_SIZE-1:0] ALUC_ADD   = ALUOP_SIZE'(ALU_ADD);
    localparam logic [ALUOP_SIZE-1:0] ALUC_SUB   = ALUOP_SIZE'(ALU_SUB);
    localparam logic [ALUOP_SIZE-1:0] ALUC_FUNCT = ALUOP_SIZE'(ALU_FUNCT);

    stateT                  state;
    ctrlT                   ctrl;
    logic                   halted;
    logic                   illegal;
    logic [OP_SIZE-1:0]     opcodeLatched;
    logic [COUNT_WIDTH-1:0] instrCount;
    stateT                  nextState;
    logic                   fetchDone;

    function automatic logic isLegal(input logic [OP_SIZE-1:0] opc);
        logic ok;
        ok = 1'b0;
        case (opc)
            OPC_RTYPE, OPC_LW, OPC_SW, OPC_ADDI,
            OPC_BEQ, OPC_J, OPC_LI, OPC_HALT: ok = 1'b1;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic stateT nextStateOf(input stateT s,
                                          input logic [OP_SIZE-1:0] opc,
                                          input logic [OP_SIZE-1:0] latched,
                                          input logic ready);
        stateT n;
        n = s;
        case (s)
            FETCH:     n = ready ? DECODE : FETCH;
            DECODE: begin
                case (opc)
                    OPC_LW, OPC_SW: n = MEM_ADDR;
                    OPC_RTYPE:      n = EXECUTE;
                    OPC_ADDI:       n = EXECUTE_I;
                    OPC_BEQ:        n = BRANCH;
                    OPC_J:          n = JUMP;
                    OPC_LI:         n = LOAD_IMM;
                    default:        n = HALT;
                endcase
            end
            MEM_ADDR:  n = (latched == OPC_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  n = ready ? MEM_WB : MEM_READ;
            MEM_WRITE: n = ready ? FETCH : MEM_WRITE;
            EXECUTE,
            EXECUTE_I: n = ALU_WB;
            MEM_WB, ALU_WB, BRANCH, JUMP, LOAD_IMM: n = FETCH;
            HALT:      n = HALT;
            default:   n = FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrlT controlsOf(input stateT s);
        ctrlT c;
        c = '0;
        case (s)
            FETCH: begin
                c.memRead = 1'b1;
                c.aluSrcB = 2'b01;
                c.aluOP   = ALUC_ADD;
            end
            DECODE: begin
                c.aluSrcB = 2'b11;
                c.aluOP   = ALUC_ADD;
            end
            MEM_ADDR, EXECUTE_I: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
                c.aluOP   = ALUC_ADD;
            end
            MEM_READ: begin
                c.memRead    = 1'b1;
                c.memGetData = 1'b1;
            end
            MEM_WB: begin
                c.regWrite        = 1'b1;
                c.regWriteDataSel = 2'b01;
            end
            MEM_WRITE: begin
                c.memWrite   = 1'b1;
                c.memGetData = 1'b1;
            end
            EXECUTE: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b00;
                c.aluOP   = ALUC_FUNCT;
            end
            ALU_WB: begin
                c.regWrite        = 1'b1;
                c.regWriteDataSel = 2'b00;
            end
            BRANCH: begin
                c.aluSrcA     = 1'b1;
                c.aluSrcB     = 2'b00;
                c.aluOP       = ALUC_SUB;
                c.pcWriteCond = 1'b1;
                c.pcSrc       = 2'b01;
            end
            JUMP: begin
                c.pcWrite = 1'b1;
                c.pcSrc   = 2'b10;
            end
            LOAD_IMM: begin
                c.regWrite        = 1'b1;
                c.regWriteDataSel = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign fetchDone = (state == FETCH) && bus.mem_ready;
    assign nextState = nextStateOf(state, bus.opcode, opcodeLatched, bus.mem_ready);

    // State, registered controls, sticky flags and the saturating retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FETCH;
            ctrl          <= controlsOf(FETCH);
            halted        <= 1'b0;
            illegal       <= 1'b0;
            opcodeLatched <= '0;
            instrCount    <= '0;
        end else begin
            state  <= nextState;
            ctrl   <= controlsOf(nextState);
            halted <= (nextState == HALT);
            if (state == DECODE) begin
                opcodeLatched <= bus.opcode;
                if (!isLegal(bus.opcode)) begin
                    illegal <= 1'b1;
                end
            end
            if (fetchDone && (instrCount != {COUNT_WIDTH{1'b1}})) begin
                instrCount <= instrCount + COUNT_WIDTH'(1);
            end
        end
    end

    assign bus.pcWrite         = ctrl.pcWrite | fetchDone;
    assign bus.irWrite         = fetchDone;
    assign bus.pcWriteCond     = ctrl.pcWriteCond;
    assign bus.memGetData      = ctrl.memGetData;
    assign bus.memRead         = ctrl.memRead;
    assign bus.memWrite        = ctrl.memWrite;
    assign bus.regWrite        = ctrl.regWrite;
    assign bus.aluSrcA         = ctrl.aluSrcA;
    assign bus.regWriteDataSel = ctrl.regWriteDataSel;
    assign bus.aluSrcB         = ctrl.aluSrcB;
    assign bus.pcSrc           = ctrl.pcSrc;
    assign bus.aluOP           = ctrl.aluOP;
    assign bus.state           = state;
    assign bus.halted          = halted;
    assign bus.illegal         = illegal;
    assign bus.instr_count     = instrCount;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a vector table walks every
// instruction class, then hand-written sequences cover illegal opcodes,
// reset during a memory wait and counter saturation on a 3-bit instance.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       memReady = 1'b0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.OP_SIZE(6), .ALUOP_SIZE(4), .COUNT_WIDTH(32)) bus ();
    multicycle_control_if #(.OP_SIZE(6), .ALUOP_SIZE(4), .COUNT_WIDTH(3))  busSmall ();

    assign bus.opcode         = opcode;
    assign bus.mem_ready      = memReady;
    assign busSmall.opcode    = opcode;
    assign busSmall.mem_ready = memReady;

    multicycle_control #(.OP_SIZE(6), .ALUOP_SIZE(4), .COUNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    multicycle_control #(.OP_SIZE(6), .ALUOP_SIZE(4), .COUNT_WIDTH(3)) dutSmall (
        .clk(clk), .rst(rst), .bus(busSmall)
    );

    logic [17:0] ctlAct;
    assign ctlAct = {bus.pcWrite, bus.pcWriteCond, bus.memGetData, bus.memRead,
                     bus.memWrite, bus.irWrite, bus.regWrite, bus.aluSrcA,
                     bus.regWriteDataSel, bus.aluSrcB, bus.pcSrc, bus.aluOP};

    function automatic logic [17:0] mkCtl(input bit pw, input bit pwc, input bit mgd,
                                          input bit mr, input bit mw, input bit ir,
                                          input bit rw, input bit sa, input bit [1:0] rwds,
                                          input bit [1:0] sb, input bit [1:0] ps,
                                          input bit [3:0] op);
        return {pw, pwc, mgd, mr, mw, ir, rw, sa, rwds, sb, ps, op};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] ctl;
        logic        halted;
        logic        illegal;
        int          cnt;
    } vecT;

    vecT vecs[$];

    logic [17:0] cFetchRdy, cFetchWait, cDecode, cMemAddr, cMemRead, cMemWb,
                 cMemWrite, cExec, cExecI, cAluWb, cBranch, cJump, cLoadImm, cIdle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [17:0] ctl, input logic h, input logic il, input int cnt);
        vecT v;
        v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl;
        v.halted = h; v.illegal = il; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        //                  pw pwc mgd mr mw ir rw sa rwds  sb     ps     op
        cFetchRdy  = mkCtl(1, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 4'd0);
        cFetchWait = mkCtl(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'd0);
        cDecode    = mkCtl(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 4'd0);
        cMemAddr   = mkCtl(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 4'd0);
        cMemRead   = mkCtl(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        cMemWb     = mkCtl(0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 4'd0);
        cMemWrite  = mkCtl(0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        cExec      = mkCtl(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd15);
        cExecI     = mkCtl(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 4'd0);
        cAluWb     = mkCtl(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        cBranch    = mkCtl(0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 4'd1);
        cJump      = mkCtl(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 4'd0);
        cLoadImm   = mkCtl(0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 4'd0);
        cIdle      = '0;

        // R-type
        add(6'd0, 1, 4'd0,  cFetchRdy,  0, 0, 0);
        add(6'd0, 1, 4'd1,  cDecode,    0, 0, 1);
        add(6'd0, 1, 4'd6,  cExec,      0, 0, 1);
        add(6'd0, 1, 4'd8,  cAluWb,     0, 0, 1);
        // ADDI
        add(6'd3, 1, 4'd0,  cFetchRdy,  0, 0, 1);
        add(6'd3, 1, 4'd1,  cDecode,    0, 0, 2);
        add(6'd3, 1, 4'd7,  cExecI,     0, 0, 2);
        add(6'd3, 1, 4'd8,  cAluWb,     0, 0, 2);
        // LW with three wait cycles in FETCH and MEM_READ; opcode bus changes after DECODE
        add(6'd1, 0, 4'd0,  cFetchWait, 0, 0, 2);
        add(6'd1, 0, 4'd0,  cFetchWait, 0, 0, 2);
        add(6'd1, 0, 4'd0,  cFetchWait, 0, 0, 2);
        add(6'd1, 1, 4'd0,  cFetchRdy,  0, 0, 2);
        add(6'd1, 1, 4'd1,  cDecode,    0, 0, 3);
        add(6'd2, 1, 4'd2,  cMemAddr,   0, 0, 3);
        add(6'd2, 0, 4'd3,  cMemRead,   0, 0, 3);
        add(6'd2, 0, 4'd3,  cMemRead,   0, 0, 3);
        add(6'd2, 0, 4'd3,  cMemRead,   0, 0, 3);
        add(6'd2, 1, 4'd3,  cMemRead,   0, 0, 3);
        add(6'd2, 1, 4'd4,  cMemWb,     0, 0, 3);
        // SW with one write wait
        add(6'd2, 1, 4'd0,  cFetchRdy,  0, 0, 3);
        add(6'd2, 1, 4'd1,  cDecode,    0, 0, 4);
        add(6'd1, 1, 4'd2,  cMemAddr,   0, 0, 4);
        add(6'd1, 0, 4'd5,  cMemWrite,  0, 0, 4);
        add(6'd1, 1, 4'd5,  cMemWrite,  0, 0, 4);
        // BEQ, J, LI
        add(6'd4, 1, 4'd0,  cFetchRdy,  0, 0, 4);
        add(6'd4, 1, 4'd1,  cDecode,    0, 0, 5);
        add(6'd4, 1, 4'd9,  cBranch,    0, 0, 5);
        add(6'd5, 1, 4'd0,  cFetchRdy,  0, 0, 5);
        add(6'd5, 1, 4'd1,  cDecode,    0, 0, 6);
        add(6'd5, 1, 4'd10, cJump,      0, 0, 6);
        add(6'd6, 1, 4'd0,  cFetchRdy,  0, 0, 6);
        add(6'd6, 1, 4'd1,  cDecode,    0, 0, 7);
        add(6'd6, 1, 4'd11, cLoadImm,   0, 0, 7);
        // HALT opcode: legal stop
        add(6'd63, 1, 4'd0,  cFetchRdy, 0, 0, 7);
        add(6'd63, 1, 4'd1,  cDecode,   0, 0, 8);
        add(6'd63, 1, 4'd12, cIdle,     1, 0, 8);
        add(6'd63, 1, 4'd12, cIdle,     1, 0, 8);

        // Reset, then FETCH outputs with irWrite/pcWrite following mem_ready
        rst = 1'b1;
        memReady = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset state", 32'(bus.state), 32'd0);
        chk("reset ctl wait", 32'(ctlAct), 32'(cFetchWait));
        chk("reset count", bus.instr_count, 32'd0);
        chk("reset illegal", 32'(bus.illegal), 32'd0);
        chk("reset halted", 32'(bus.halted), 32'd0);
        memReady = 1'b1;
        #1;
        chk("reset ctl ready", 32'(ctlAct), 32'(cFetchRdy));

        for (int i = 0; i < vecs.size(); i++) begin
            opcode   = vecs[i].op;
            memReady = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d state", i), 32'(bus.state), 32'(vecs[i].st));
            chk($sformatf("vec%0d ctl", i), 32'(ctlAct), 32'(vecs[i].ctl));
            chk($sformatf("vec%0d halted", i), 32'(bus.halted), 32'(vecs[i].halted));
            chk($sformatf("vec%0d illegal", i), 32'(bus.illegal), 32'(vecs[i].illegal));
            chk($sformatf("vec%0d count", i), bus.instr_count, 32'(vecs[i].cnt));
            tick();
        end

        // Leave HALT by reset; reset held in FETCH with mem_ready must not count
        rst = 1'b1;
        opcode = 6'd0;
        memReady = 1'b1;
        tick();
        chk("halt rst state", 32'(bus.state), 32'd0);
        chk("halt rst halted", 32'(bus.halted), 32'd0);
        tick();
        chk("rst priority count", bus.instr_count, 32'd0);
        chk("rst priority state", 32'(bus.state), 32'd0);
        rst = 1'b0;

        // Illegal opcode 6'h20
        opcode = 6'h20;
        tick();
        tick();
        chk("illegal state", 32'(bus.state), 32'd12);
        chk("illegal flag", 32'(bus.illegal), 32'd1);
        chk("illegal halted", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("illegal hold%0d state", i), 32'(bus.state), 32'd12);
            chk($sformatf("illegal hold%0d flag", i), 32'(bus.illegal), 32'd1);
            chk($sformatf("illegal hold%0d ctl", i), 32'(ctlAct), 32'd0);
        end
        chk("illegal count", bus.instr_count, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("illegal rst state", 32'(bus.state), 32'd0);
        chk("illegal rst flag", 32'(bus.illegal), 32'd0);

        // Reset during a MEM_WRITE wait
        opcode = 6'd2;
        memReady = 1'b1;
        tick();
        tick();
        tick();
        memReady = 1'b0;
        #1;
        chk("sw wait state", 32'(bus.state), 32'd5);
        chk("sw wait memWrite", 32'(bus.memWrite), 32'd1);
        tick();
        chk("sw wait hold", 32'(bus.state), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("sw rst state", 32'(bus.state), 32'd0);
        chk("sw rst memWrite", 32'(bus.memWrite), 32'd0);
        chk("sw rst count", bus.instr_count, 32'd0);

        // Nine LI instructions: 3-bit counter saturates at 7
        opcode = 6'd6;
        memReady = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            tick();
            tick();
            chk($sformatf("li%0d state", i), 32'(bus.state), 32'd0);
            chk($sformatf("li%0d count", i), bus.instr_count, 32'(i + 1));
            chk($sformatf("li%0d small count", i), 32'(busSmall.instr_count),
                (i + 1 > 7) ? 32'd7 : 32'(i + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter OP_SIZE, default 6, meaning the opcode width.
REQ-002 The block SHALL have parameter ALUOP_SIZE, default 4, meaning the aluOP width.
REQ-003 The block SHALL have parameter COUNT_WIDTH, default 32, meaning the retired-instruction counter width.
REQ-004 The block SHALL have opcode parameters OP_RTYPE=0, OP_LW=1, OP_SW=2, OP_ADDI=3, OP_BEQ=4, OP_J=5, OP_LI=6 and OP_HALT=63.
REQ-005 The block SHALL have ALU code parameters ALU_ADD=0, ALU_SUB=1 and ALU_FUNCT=15 (ALU decodes the IR funct field).
REQ-006 The block SHALL use one clock and a synchronous, active-high reset, with ports: clk in 1 (clock); rst in 1 (synchronous active-high reset).
REQ-007 The block SHALL have these inputs: opcode in OP_SIZE (IR opcode field); mem_ready in 1 (memory completes the current access this cycle).
REQ-008 The block SHALL have these outputs, all 1 bit: pcWrite, pcWriteCond, memGetData (0=PC address, 1=ALUOut address), memRead, memWrite, irWrite, regWrite, aluSrcA (0=PC, 1=regA).
REQ-009 The block SHALL have these outputs: regWriteDataSel out 2 (00=ALUOut, 01=MDR, 10=sign-extended big immediate); aluSrcB out 2 (00=regB, 01=constant 1, 10=sign-extended offset, 11=shifted offset); pcSrc out 2 (00=ALU, 01=ALUOut, 10=jump address); aluOP out ALUOP_SIZE.
REQ-010 The block SHALL have these status outputs: state out 4 (current state); halted out 1; illegal out 1 (sticky); instr_count out COUNT_WIDTH.

Function
REQ-011 The block SHALL be a Moore FSM with these encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, EXECUTE_I=7, ALU_WB=8, BRANCH=9, JUMP=10, LOAD_IMM=11, HALT=12.
REQ-012 Every control output SHALL be 0 unless listed for the current state; outputs SHALL depend only on state, except that irWrite and pcWrite in FETCH also depend on mem_ready.
REQ-013 FETCH SHALL drive memRead=1, memGetData=0, aluSrcB=01, aluOP=ALU_ADD and pcSrc=00, with irWrite=pcWrite=mem_ready; it SHALL go to DECODE if mem_ready, else remain in FETCH.
REQ-014 DECODE SHALL drive aluSrcB=11 and aluOP=ALU_ADD, latch opcode internally, and go to: LW/SW->MEM_ADDR, RTYPE->EXECUTE, ADDI->EXECUTE_I, BEQ->BRANCH, J->JUMP, LI->LOAD_IMM, HALT->HALT; any other opcode->HALT with illegal set to 1.
REQ-015 MEM_ADDR SHALL drive aluSrcA=1, aluSrcB=10 and aluOP=ALU_ADD, then go to MEM_READ if the latched opcode is LW, else MEM_WRITE.
REQ-016 MEM_READ SHALL drive memRead=1 and memGetData=1, and go to MEM_WB on mem_ready, else hold.
REQ-017 MEM_WB SHALL drive regWrite=1 and regWriteDataSel=01, then go to FETCH.
REQ-018 MEM_WRITE SHALL drive memWrite=1 and memGetData=1, and go to FETCH on mem_ready, else hold.
REQ-019 EXECUTE SHALL drive aluSrcA=1, aluSrcB=00 and aluOP=ALU_FUNCT; EXECUTE_I SHALL drive aluSrcA=1, aluSrcB=10 and aluOP=ALU_ADD; both SHALL go to ALU_WB.
REQ-020 ALU_WB SHALL drive regWrite=1 and regWriteDataSel=00, then go to FETCH.
REQ-021 BRANCH SHALL drive aluSrcA=1, aluSrcB=00, aluOP=ALU_SUB, pcWriteCond=1 and pcSrc=01, then go to FETCH.
REQ-022 JUMP SHALL drive pcWrite=1 and pcSrc=10, then go to FETCH.
REQ-023 LOAD_IMM SHALL drive regWrite=1 and regWriteDataSel=10, then go to FETCH.
REQ-024 HALT SHALL drive all controls to 0 and halted=1, and hold until rst.
REQ-025 instr_count SHALL increment by 1 on every cycle with FETCH and mem_ready both 1, and SHALL saturate at all-ones rather than wrapping.
REQ-026 Once set, illegal SHALL stay 1 until rst.
REQ-027 Latency SHALL be (excluding memory wait cycles): R/ADDI/LW 4–5 cycles, SW 4, BEQ/J/LI 3.

Reset
REQ-028 When rst=1 at a clk edge, the block SHALL enter FETCH and clear instr_count, illegal, halted and the latched opcode, from any state including mid-memory-wait; rst SHALL take priority over mem_ready.
REQ-029 In the cycle after reset, the outputs SHALL equal the FETCH values, with irWrite and pcWrite following mem_ready.

Verification
REQ-030 With opcode=0 and mem_ready=1 held, the state sequence SHALL be 0,1,6,8,0, and instr_count SHALL reach 1 after the first FETCH.
REQ-031 With opcode=1 and mem_ready low for 3 cycles in both FETCH and MEM_READ, the block SHALL hold each of those states 3 extra cycles with irWrite=0 while waiting, then follow 2,3,4 with regWriteDataSel=01 in state 4.
REQ-032 With opcode=4, BRANCH SHALL show pcWriteCond=1, pcSrc=01 and aluOP=1; with opcode=5, JUMP SHALL show pcWrite=1 and pcSrc=10; both SHALL return to FETCH.
REQ-033 With opcode=6'h20, the block SHALL show state=12, illegal=1 and halted=1, remain there 10 cycles, and after rst show state=0 and illegal=0.
REQ-034 With rst asserted during MEM_WRITE while mem_ready=0, the next state SHALL be FETCH, memWrite SHALL be 0 and instr_count SHALL be 0.
REQ-035 With COUNT_WIDTH=3 and 9 LI instructions, instr_count SHALL saturate at 7.
